// File: rtl/dmi_req_queue.sv
// dmi_req_queue: buffered DMI request/response path between the DTM and the
// debug module front-end. Up to DEPTH requests may be outstanding. The block
// keeps a sticky busy/failed status that the DTM sees. dmireset clears that
// status. dmihardreset flushes the queues and silently eats the responses to
// requests that were already handed to the DM.
module dmi_req_queue #(
    parameter int ABITS  = 7,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       dtm_req_valid_i,
    output logic                       dtm_req_ready_o,
    input  logic [ABITS-1:0]           dtm_req_addr_i,
    input  logic [1:0]                 dtm_req_op_i,
    input  logic [DATA_W-1:0]          dtm_req_data_i,
    output logic                       dtm_resp_valid_o,
    input  logic                       dtm_resp_ready_i,
    output logic [DATA_W-1:0]          dtm_resp_data_o,
    output logic [1:0]                 dtm_resp_resp_o,
    output logic                       dm_req_valid_o,
    input  logic                       dm_req_ready_i,
    output logic [ABITS-1:0]           dm_req_addr_o,
    output logic [1:0]                 dm_req_op_o,
    output logic [DATA_W-1:0]          dm_req_data_o,
    input  logic                       dm_resp_valid_i,
    output logic                       dm_resp_ready_o,
    input  logic [DATA_W-1:0]          dm_resp_data_i,
    input  logic [1:0]                 dm_resp_resp_i,
    input  logic                       dmireset_i,
    input  logic                       dmihardreset_i,
    output logic [1:0]                 dmistat_o,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // inflight/discard can exceed DEPTH when several hard resets land while the
    // DM is still sitting on requests. Keep some headroom above the queue size.
    localparam int INF_W = CNT_W + 4;
    localparam int REQ_W = ABITS + 2 + DATA_W;
    localparam int RSP_W = 2 + DATA_W;

    localparam logic [1:0] STAT_OK     = 2'd0;
    localparam logic [1:0] STAT_FAILED = 2'd2;
    localparam logic [1:0] STAT_BUSY   = 2'd3;

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    // Circular pointer advance that works for non-power-of-two depths
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [1:0]       dmistat_q, dmistat_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic [INF_W-1:0] discard_q, discard_d;

    logic [REQ_W-1:0] req_mem_q [DEPTH];
    logic [REQ_W-1:0] req_mem_d [DEPTH];
    logic [PTR_W-1:0] req_wr_ptr_q, req_wr_ptr_d;
    logic [PTR_W-1:0] req_rd_ptr_q, req_rd_ptr_d;
    logic [CNT_W-1:0] req_cnt_q, req_cnt_d;

    logic [RSP_W-1:0] rsp_mem_q [DEPTH];
    logic [RSP_W-1:0] rsp_mem_d [DEPTH];
    logic [PTR_W-1:0] rsp_wr_ptr_q, rsp_wr_ptr_d;
    logic [PTR_W-1:0] rsp_rd_ptr_q, rsp_rd_ptr_d;
    logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;

    // ---------------------------------------------------------------------
    // Handshakes and request classification
    // ---------------------------------------------------------------------
    logic req_is_rw;
    logic req_is_rsvd;
    logic room;
    logic accept;
    logic dtm_resp_hs;
    logic dm_req_hs;
    logic dm_resp_hs;
    logic discarding;
    logic rsp_full;
    logic rsp_push;
    logic [REQ_W-1:0] req_head;
    logic [RSP_W-1:0] rsp_head;

    assign dtm_req_ready_o = 1'b1;

    assign dm_req_valid_o   = (req_cnt_q != '0);
    assign dtm_resp_valid_o = (rsp_cnt_q != '0);
    assign rsp_full         = (rsp_cnt_q == CNT_W'(DEPTH));
    assign discarding       = (discard_q != '0);
    // While discarding, responses are swallowed, so a full queue must not block them
    assign dm_resp_ready_o  = !rsp_full || discarding;

    assign dtm_resp_hs = dtm_resp_valid_o && dtm_resp_ready_i;
    assign dm_req_hs   = dm_req_valid_o && dm_req_ready_i;
    assign dm_resp_hs  = dm_resp_valid_i && dm_resp_ready_o;

    assign req_is_rw   = dtm_req_valid_i &&
                         ((dtm_req_op_i == OP_READ) || (dtm_req_op_i == OP_WRITE));
    assign req_is_rsvd = dtm_req_valid_i && (dtm_req_op_i == OP_RSVD);
    // A response leaving to the DTM this cycle frees a slot for a new request
    assign room        = (outstanding_q < CNT_W'(DEPTH)) || dtm_resp_hs;
    // Requests that arrive together with either reset pulse are dropped quietly
    assign accept      = req_is_rw && (dmistat_q == STAT_OK) && room &&
                         !dmireset_i && !dmihardreset_i;
    // Responses owed to flushed requests, or ones arriving during the flush, are dropped
    assign rsp_push    = dm_resp_hs && !discarding && !dmihardreset_i;

    // Outputs read zero while the queue head is empty
    assign req_head = dm_req_valid_o ? req_mem_q[req_rd_ptr_q] : '0;
    assign rsp_head = dtm_resp_valid_o ? rsp_mem_q[rsp_rd_ptr_q] : '0;

    assign dm_req_addr_o   = req_head[REQ_W-1 -: ABITS];
    assign dm_req_op_o     = req_head[DATA_W +: 2];
    assign dm_req_data_o   = req_head[DATA_W-1:0];
    assign dtm_resp_resp_o = rsp_head[DATA_W +: 2];
    assign dtm_resp_data_o = rsp_head[DATA_W-1:0];

    assign dmistat_o     = dmistat_q;
    assign outstanding_o = outstanding_q;

    // Sticky status. Only the first error after a clear is recorded.
    always_comb begin
        dmistat_d = dmistat_q;
        if (dmihardreset_i || dmireset_i) begin
            dmistat_d = STAT_OK;
        end else if (dmistat_q == STAT_OK) begin
            if (req_is_rw && !room) begin
                dmistat_d = STAT_BUSY;
            end else if (req_is_rsvd) begin
                dmistat_d = STAT_FAILED;
            end else if (rsp_push && (dm_resp_resp_i != 2'd0)) begin
                dmistat_d = STAT_FAILED;
            end
        end
    end

    // Outstanding, inflight and discard bookkeeping
    always_comb begin
        outstanding_d = outstanding_q;
        if (dmihardreset_i) begin
            outstanding_d = '0;
        end else if (accept && !dtm_resp_hs) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!accept && dtm_resp_hs) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

        inflight_d = inflight_q;
        if (dm_req_hs && !dm_resp_hs) begin
            inflight_d = inflight_q + INF_W'(1);
        end else if (!dm_req_hs && dm_resp_hs) begin
            inflight_d = inflight_q - INF_W'(1);
        end

        discard_d = discard_q;
        if (dmihardreset_i) begin
            // Everything the DM still owes after this cycle belongs to flushed requests
            discard_d = inflight_d;
        end else if (dm_resp_hs && discarding) begin
            discard_d = discard_q - INF_W'(1);
        end
    end

    // Request FIFO next-state: push on accept, pop on DM handshake
    always_comb begin
        req_mem_d    = req_mem_q;
        req_wr_ptr_d = req_wr_ptr_q;
        req_rd_ptr_d = req_rd_ptr_q;
        req_cnt_d    = req_cnt_q;
        if (dmihardreset_i) begin
            req_wr_ptr_d = '0;
            req_rd_ptr_d = '0;
            req_cnt_d    = '0;
        end else begin
            if (accept) begin
                req_mem_d[req_wr_ptr_q] = {dtm_req_addr_i, dtm_req_op_i, dtm_req_data_i};
                req_wr_ptr_d = ptr_inc(req_wr_ptr_q);
            end
            if (dm_req_hs) begin
                req_rd_ptr_d = ptr_inc(req_rd_ptr_q);
            end
            if (accept && !dm_req_hs) begin
                req_cnt_d = req_cnt_q + CNT_W'(1);
            end else if (!accept && dm_req_hs) begin
                req_cnt_d = req_cnt_q - CNT_W'(1);
            end
        end
    end

    // Response FIFO next-state: push on kept DM response, pop on DTM handshake
    always_comb begin
        rsp_mem_d    = rsp_mem_q;
        rsp_wr_ptr_d = rsp_wr_ptr_q;
        rsp_rd_ptr_d = rsp_rd_ptr_q;
        rsp_cnt_d    = rsp_cnt_q;
        if (dmihardreset_i) begin
            rsp_wr_ptr_d = '0;
            rsp_rd_ptr_d = '0;
            rsp_cnt_d    = '0;
        end else begin
            if (rsp_push) begin
                rsp_mem_d[rsp_wr_ptr_q] = {dm_resp_resp_i, dm_resp_data_i};
                rsp_wr_ptr_d = ptr_inc(rsp_wr_ptr_q);
            end
            if (dtm_resp_hs) begin
                rsp_rd_ptr_d = ptr_inc(rsp_rd_ptr_q);
            end
            if (rsp_push && !dtm_resp_hs) begin
                rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
            end else if (!rsp_push && dtm_resp_hs) begin
                rsp_cnt_d = rsp_cnt_q - CNT_W'(1);
            end
        end
    end

    // Control and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dmistat_q     <= STAT_OK;
            outstanding_q <= '0;
            inflight_q    <= '0;
            discard_q     <= '0;
            req_wr_ptr_q  <= '0;
            req_rd_ptr_q  <= '0;
            req_cnt_q     <= '0;
            rsp_wr_ptr_q  <= '0;
            rsp_rd_ptr_q  <= '0;
            rsp_cnt_q     <= '0;
        end else begin
            dmistat_q     <= dmistat_d;
            outstanding_q <= outstanding_d;
            inflight_q    <= inflight_d;
            discard_q     <= discard_d;
            req_wr_ptr_q  <= req_wr_ptr_d;
            req_rd_ptr_q  <= req_rd_ptr_d;
            req_cnt_q     <= req_cnt_d;
            rsp_wr_ptr_q  <= rsp_wr_ptr_d;
            rsp_rd_ptr_q  <= rsp_rd_ptr_d;
            rsp_cnt_q     <= rsp_cnt_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            // Storage for one request slot and one response slot
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    req_mem_q[gi] <= '0;
                    rsp_mem_q[gi] <= '0;
                end else begin
                    req_mem_q[gi] <= req_mem_d[gi];
                    rsp_mem_q[gi] <= rsp_mem_d[gi];
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Protocol and capacity assertions
    // ---------------------------------------------------------------------
    a_dm_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (dm_req_valid_o && !dm_req_ready_i && !dmihardreset_i) |=>
        (dm_req_valid_o && $stable({dm_req_addr_o, dm_req_op_o, dm_req_data_o})));

    a_dtm_resp_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (dtm_resp_valid_o && !dtm_resp_ready_i && !dmihardreset_i) |=>
        (dtm_resp_valid_o && $stable({dtm_resp_resp_o, dtm_resp_data_o})));

    a_outstanding_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding_q <= CNT_W'(DEPTH));

    a_rsp_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_push |-> (!rsp_full || dtm_resp_hs));

    a_req_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> ((req_cnt_q < CNT_W'(DEPTH)) || dm_req_hs));

endmodule
